thinning_ctrl: RTL and testbench

//  Sequences the combinational thinning datapath over a binary image stored one 32-px row per word.

---
 rtl/thinning_ctrl_pkg.sv | 18 +
 rtl/thinning_ctrl_if.sv | 34 +++
 rtl/thinning_ctrl.sv | 135 +++++++++++++
 tb/tb_thinning_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/thinning_ctrl_pkg.sv
// Shared definitions for the thinning pass sequencer: row width and FSM state encoding.
package thinning_ctrl_pkg;

  localparam int ROW_W = 32;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_PRIME0 = 4'd1,
    S_PRIME1 = 4'd2,
    S_PRIME2 = 4'd3,
    S_WRITE  = 4'd4,
    S_FETCH  = 4'd5,
    S_SHIFT  = 4'd6,
    S_CHECK  = 4'd7,
    S_DONE   = 4'd8
  } state_t;

endpackage

// File: rtl/thinning_ctrl_if.sv
// Control, frame-memory and thinning-datapath signals of the pass sequencer.
interface thinning_ctrl_if #(
  parameter int ADDR_W = 10
);
  import thinning_ctrl_pkg::*;

  logic              start;
  logic              busy;
  logic              done;
  logic [3:0]        pass_count;
  logic [ADDR_W-1:0] final_base;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [ROW_W-1:0]  mem_rdata;
  logic              mem_wr_en;
  logic [ROW_W-1:0]  mem_wdata;
  logic [ROW_W-1:0]  thin_top;
  logic [ROW_W-1:0]  thin_center;
  logic [ROW_W-1:0]  thin_bottom;
  logic [ROW_W-1:0]  thin_result;

  modport master (
    input  start, mem_rdata, thin_result,
    output busy, done, pass_count, final_base, mem_addr, mem_rd_en,
           mem_wr_en, mem_wdata, thin_top, thin_center, thin_bottom
  );

  modport slave (
    output start, mem_rdata, thin_result,
    input  busy, done, pass_count, final_base, mem_addr, mem_rd_en,
           mem_wr_en, mem_wdata, thin_top, thin_center, thin_bottom
  );

endinterface

// File: rtl/thinning_ctrl.sv
// Streams 3-row windows from the source buffer through the external thinning datapath,
// writes each result row to the other buffer, and repeats passes until stable or at the pass limit.
module thinning_ctrl
  import thinning_ctrl_pkg::*;
#(
  parameter int ROWS       = 32,
  parameter int ADDR_W     = 10,
  parameter int MAX_PASSES = 8,
  parameter int BUF_A      = 0,
  parameter int BUF_B      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  thinning_ctrl_if.master bus
);

  localparam logic [ADDR_W:0] ROWS_L = (ADDR_W+1)'(ROWS);
  localparam logic [3:0]      MAXP   = 4'(MAX_PASSES);
  localparam logic            MULTI  = (ROWS > 1);

  state_t              state, nxt;
  logic [ADDR_W-1:0]   src, dst, r, addr_q, addr;
  logic [ROW_W-1:0]    top_r, ctr_r, bot_r;
  logic [3:0]          pass_cnt;
  logic [ADDR_W-1:0]   fbase;
  logic                chg, rd_en, wr_en;
  logic [ADDR_W:0]     r_plus2;
  logic                fetch_ok, last_row;

  assign r_plus2  = {1'b0, r} + (ADDR_W+1)'(2);
  assign fetch_ok = (r_plus2 < ROWS_L);
  assign last_row = ({1'b0, r} == ROWS_L - (ADDR_W+1)'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt   = state;
    rd_en = 1'b0;
    wr_en = 1'b0;
    addr  = addr_q;
    case (state)
      S_IDLE:   if (bus.start) nxt = S_PRIME0;
      S_PRIME0: begin
        rd_en = 1'b1;
        addr  = src;
        nxt   = S_PRIME1;
      end
      S_PRIME1: begin
        rd_en = MULTI;
        if (MULTI) addr = src + ADDR_W'(1);
        nxt = S_PRIME2;
      end
      S_PRIME2: nxt = S_WRITE;
      S_WRITE: begin
        wr_en = 1'b1;
        addr  = dst + r;
        nxt   = last_row ? S_CHECK : S_FETCH;
      end
      // Rows past the bottom edge are never read; SHIFT substitutes zero.
      S_FETCH: begin
        rd_en = fetch_ok;
        if (fetch_ok) addr = src + r + ADDR_W'(2);
        nxt = S_SHIFT;
      end
      S_SHIFT:  nxt = S_WRITE;
      S_CHECK:  nxt = (!chg || (pass_cnt + 4'd1 == MAXP)) ? S_DONE : S_PRIME0;
      S_DONE:   nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src      <= '0;
      dst      <= '0;
      r        <= '0;
      chg      <= 1'b0;
      top_r    <= '0;
      ctr_r    <= '0;
      bot_r    <= '0;
      pass_cnt <= '0;
      fbase    <= ADDR_W'(BUF_A);
      addr_q   <= '0;
    end else begin
      if (rd_en || wr_en) addr_q <= addr;
      case (state)
        S_IDLE: if (bus.start) begin
          src      <= ADDR_W'(BUF_A);
          dst      <= ADDR_W'(BUF_B);
          pass_cnt <= '0;
        end
        S_PRIME1: ctr_r <= bus.mem_rdata;
        S_PRIME2: begin
          bot_r <= MULTI ? bus.mem_rdata : '0;
          top_r <= '0;
          r     <= '0;
          chg   <= 1'b0;
        end
        S_WRITE: if (bus.thin_result != ctr_r) chg <= 1'b1;
        S_SHIFT: begin
          top_r <= ctr_r;
          ctr_r <= bot_r;
          bot_r <= fetch_ok ? bus.mem_rdata : '0;
          r     <= r + ADDR_W'(1);
        end
        // The buffer just written becomes the source of the next pass.
        S_CHECK: begin
          pass_cnt <= pass_cnt + 4'd1;
          fbase    <= dst;
          if (nxt == S_PRIME0) begin
            src <= dst;
            dst <= src;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != S_IDLE) && (state != S_DONE);
  assign bus.done        = (state == S_DONE);
  assign bus.pass_count  = pass_cnt;
  assign bus.final_base  = fbase;
  assign bus.mem_addr    = addr;
  assign bus.mem_rd_en   = rd_en;
  assign bus.mem_wr_en   = wr_en;
  assign bus.mem_wdata   = bus.thin_result;
  assign bus.thin_top    = top_r;
  assign bus.thin_center = ctr_r;
  assign bus.thin_bottom = bot_r;

endmodule

// File: tb/tb_thinning_ctrl.sv
// Bench: two sequencer instances (4-row/8-pass, 1-row/1-pass) with RAM models and a stand-in thinning rule.
module tb_thinning_ctrl;
  import thinning_ctrl_pkg::*;

  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  thinning_ctrl_if #(.ADDR_W(AW)) ifa ();
  thinning_ctrl_if #(.ADDR_W(AW)) ifb ();

  thinning_ctrl #(.ROWS(4), .ADDR_W(AW), .MAX_PASSES(8), .BUF_A(0), .BUF_B(4))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  thinning_ctrl #(.ROWS(1), .ADDR_W(AW), .MAX_PASSES(1), .BUF_A(0), .BUF_B(4))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  // Stand-in thinning rule: keep a pixel if its left neighbour is set or it is vertically enclosed.
  function automatic logic [31:0] thin_f(logic [31:0] t, logic [31:0] c, logic [31:0] b);
    return c & ((c << 1) | (t & b));
  endfunction

  assign ifa.thin_result = thin_f(ifa.thin_top, ifa.thin_center, ifa.thin_bottom);
  assign ifb.thin_result = thin_f(ifb.thin_top, ifb.thin_center, ifb.thin_bottom);

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic        ld_en = 1'b0, ld_sel = 1'b0;
  logic [5:0]  ld_addr = '0;
  logic [31:0] ld_data = '0;

  always @(posedge clk) begin
    if (ld_en && !ld_sel) mem_a[ld_addr] <= ld_data;
    if (ld_en &&  ld_sel) mem_b[ld_addr] <= ld_data;
    if (ifa.mem_wr_en) mem_a[ifa.mem_addr[5:0]] <= ifa.mem_wdata;
    if (ifa.mem_rd_en) ifa.mem_rdata <= mem_a[ifa.mem_addr[5:0]];
    if (ifb.mem_wr_en) mem_b[ifb.mem_addr[5:0]] <= ifb.mem_wdata;
    if (ifb.mem_rd_en) ifb.mem_rdata <= mem_b[ifb.mem_addr[5:0]];
  end

  // Strobe log
  logic        clr = 1'b0;
  int          wcnt, rcnt, bw;
  logic        ovl;
  logic [9:0]  wlog_a [64];
  logic [31:0] wlog_d [64];
  logic [9:0]  rlog_a [64];
  logic [9:0]  bw_addr;
  logic [31:0] b_edge;

  always @(posedge clk) begin
    if (clr) begin
      wcnt <= 0; rcnt <= 0; bw <= 0; ovl <= 1'b0; b_edge <= '0; bw_addr <= '0;
    end else begin
      if (ifa.mem_wr_en && wcnt < 64) begin
        wlog_a[wcnt] <= ifa.mem_addr;
        wlog_d[wcnt] <= ifa.mem_wdata;
      end
      if (ifa.mem_wr_en) wcnt <= wcnt + 1;
      if (ifa.mem_rd_en && rcnt < 64) rlog_a[rcnt] <= ifa.mem_addr;
      if (ifa.mem_rd_en) rcnt <= rcnt + 1;
      if ((ifa.mem_rd_en && ifa.mem_wr_en) || (ifb.mem_rd_en && ifb.mem_wr_en)) ovl <= 1'b1;
      if (ifb.mem_wr_en) begin
        bw      <= bw + 1;
        bw_addr <= ifb.mem_addr;
        b_edge  <= ifb.thin_top | ifb.thin_bottom;
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic load(input logic sel, input int a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_sel = sel; ld_addr = 6'(a); ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic clear_log();
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1; clr = 1'b0;
  endtask

  // Reference model over a 4-row image
  logic [31:0] mimg [4];
  logic [31:0] mtmp [4];

  task automatic model_run(input int maxp, output int np);
    bit ch;
    logic [31:0] t, b;
    np = 0;
    do begin
      ch = 1'b0;
      for (int i = 0; i < 4; i++) begin
        t = (i == 0) ? 32'h0 : mimg[i-1];
        b = (i == 3) ? 32'h0 : mimg[i+1];
        mtmp[i] = thin_f(t, mimg[i], b);
        if (mtmp[i] != mimg[i]) ch = 1'b1;
      end
      for (int i = 0; i < 4; i++) mimg[i] = mtmp[i];
      np++;
    end while (ch && np < maxp);
  endtask

  task automatic load_img(input logic [31:0] r0, r1, r2, r3);
    load(1'b0, 0, r0); load(1'b0, 1, r1); load(1'b0, 2, r2); load(1'b0, 3, r3);
    mimg[0] = r0; mimg[1] = r1; mimg[2] = r2; mimg[3] = r3;
  endtask

  task automatic run(input bit sel, input bit poke, output int cyc);
    @(negedge clk);
    if (!sel) ifa.start = 1'b1; else ifb.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0; ifb.start = 1'b0;
    cyc = 1;
    while (!(sel ? ifb.done : ifa.done) && cyc < 400) begin
      if (poke && (cyc == 5 || cyc == 20 || cyc == 40)) ifa.start = 1'b1;
      @(posedge clk); #1;
      ifa.start = 1'b0;
      cyc++;
    end
    check("done_within_bound", 64'(cyc < 400), 64'd1);
  endtask

  task automatic check_final_a(input string tag, input int np);
    int base;
    base = (np % 2 == 1) ? 4 : 0;
    check({tag, "_pass_count"}, 64'(ifa.pass_count), 64'(np));
    check({tag, "_final_base"}, 64'(ifa.final_base), 64'(base));
    check({tag, "_wcnt"}, 64'(wcnt), 64'(4 * np));
    for (int i = 0; i < 4; i++) check({tag, "_row"}, 64'(mem_a[base + i]), 64'(mimg[i]));
    check({tag, "_no_rd_wr_overlap"}, 64'(ovl), 64'd0);
  endtask

  initial begin
    int cyc, np, bound;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(ifa.busy), 64'd0);
    check("rst_done", 64'(ifa.done), 64'd0);
    check("rst_rd_en", 64'(ifa.mem_rd_en), 64'd0);
    check("rst_wr_en", 64'(ifa.mem_wr_en), 64'd0);
    check("rst_pass_count", 64'(ifa.pass_count), 64'd0);
    check("rst_final_base", 64'(ifa.final_base), 64'd0);
    check("rst_mem_addr", 64'(ifa.mem_addr), 64'd0);
    check("rst_window", 64'(ifa.thin_top | ifa.thin_center | ifa.thin_bottom), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // All-zero image: one stable pass
    load_img(32'h0, 32'h0, 32'h0, 32'h0);
    clear_log();
    run(1'b0, 1'b0, cyc);
    check("zero_done_cycle", 64'(cyc), 64'd15);
    check("zero_busy_at_done", 64'(ifa.busy), 64'd0);
    np = 1;
    check_final_a("zero", np);
    for (int i = 0; i < 4; i++) begin
      check("zero_waddr", 64'(wlog_a[i]), 64'(4 + i));
      check("zero_wdata", 64'(wlog_d[i]), 64'd0);
    end
    @(posedge clk); #1;
    check("zero_done_one_cycle", 64'(ifa.done), 64'd0);

    // Isolated pixel vanishes in pass 1, pass 2 sees no change
    load_img(32'h0, 32'h1, 32'h0, 32'h0);
    model_run(8, np);
    clear_log();
    run(1'b0, 1'b0, cyc);
    check("iso_np", 64'(np), 64'd2);
    check("iso_done_cycle", 64'(cyc), 64'(np * 14 + 1));
    check_final_a("iso", np);

    // Never-stable image runs to the pass limit; start pulses mid-run are ignored
    load_img(32'h00EF00FF, 32'h00EF00FF, 32'h00EF00FF, 32'h00EF00FF);
    model_run(8, np);
    clear_log();
    run(1'b0, 1'b1, cyc);
    check("limit_done_cycle", 64'(cyc), 64'(np * 14 + 1));
    check_final_a("limit", np);
    check("limit_rcnt", 64'(rcnt), 64'(4 * np));
    check("limit_pass1_row1", 64'(wlog_d[1]), 64'h00EF00FF);
    check("limit_pass1_row0", 64'(wlog_d[0]), 64'h00CE00FE);

    // Abort during pass-2 FETCH
    load_img(32'h00EF00FF, 32'h00EF00FF, 32'h00EF00FF, 32'h00EF00FF);
    clear_log();
    @(negedge clk); ifa.start = 1'b1;
    @(posedge clk); #1; ifa.start = 1'b0;
    bound = 0;
    while (!(ifa.pass_count == 4'd1 && ifa.mem_rd_en && ifa.mem_addr == 10'd6) && bound < 200) begin
      @(posedge clk); #1;
      bound++;
    end
    check("abort_reached_fetch", 64'(bound < 200), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(ifa.busy), 64'd0);
    check("abort_rd_en", 64'(ifa.mem_rd_en), 64'd0);
    check("abort_wr_en", 64'(ifa.mem_wr_en), 64'd0);
    check("abort_pass_count", 64'(ifa.pass_count), 64'd0);
    check("abort_final_base", 64'(ifa.final_base), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_quiet", 64'(ifa.mem_rd_en | ifa.mem_wr_en), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    load_img(32'h00EF00FF, 32'h00EF00FF, 32'h00EF00FF, 32'h00EF00FF);
    model_run(8, np);
    clear_log();
    run(1'b0, 1'b0, cyc);
    check("rerun_first_rd", 64'(rlog_a[0]), 64'd0);
    check("rerun_second_rd", 64'(rlog_a[1]), 64'd1);
    check("rerun_done_cycle", 64'(cyc), 64'(np * 14 + 1));
    check_final_a("rerun", np);

    // Single-row image, single-pass limit
    load(1'b1, 0, 32'hFFFFFFFF);
    clear_log();
    run(1'b1, 1'b0, cyc);
    check("row1_done_cycle", 64'(cyc), 64'd6);
    check("row1_pass_count", 64'(ifb.pass_count), 64'd1);
    check("row1_final_base", 64'(ifb.final_base), 64'd4);
    check("row1_writes", 64'(bw), 64'd1);
    check("row1_waddr", 64'(bw_addr), 64'd4);
    check("row1_edges_zero", 64'(b_edge), 64'd0);
    check("row1_result", 64'(mem_b[4]), 64'hFFFFFFFE);
    check("row1_overlap", 64'(ovl), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
